tns_dec_iter: RTL

TNS_DEC_ITER -- requirements
Module: tns_dec_iter

---
 rtl/tns_dec_iter.sv | 113 +++++++++++
 1 files changed

// File: rtl/tns_dec_iter.sv
// tns_dec_iter: iterative tribonacci-numeral-system decoder, BPC codeword bits per cycle.
module tns_dec_iter #(
    parameter int CW  = 22,
    parameter int DW  = 20,
    parameter int BPC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] codein,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          err,
    output logic          ovf
);
    localparam int NSTEP = (CW + BPC - 1) / BPC;
    localparam int SW    = NSTEP * BPC;
    localparam int SCW   = NSTEP > 1 ? $clog2(NSTEP) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]     state;
    logic [SW-1:0]  sh;
    logic [SCW-1:0] step;
    logic [DW-1:0]  acc, w0, w1, w2;
    logic           f0, f1, f2;
    logic [1:0]     prev;
    logic [DW-1:0]  acc_n, wn0, wn1, wn2;
    logic           fn0, fn1, fn2, err_n, ovf_n;
    logic [1:0]     prev_n;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign dataout   = acc;
    // f flags a weight that no longer fits in DW bits; adding one always overflows the true sum
    always_comb begin : calc
        logic [DW-1:0]  w [BPC+3];
        logic           f [BPC+3];
        logic [DW+1:0]  s;
        logic [DW:0]    a;
        logic [BPC+1:0] b;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        f[0] = f0;
        f[1] = f1;
        f[2] = f2;
        acc_n = acc;
        ovf_n = ovf;
        err_n = err;
        b = {sh[BPC-1:0], prev};
        s = '0;
        a = '0;
        for (int j = 0; j < BPC; j++) begin
            s = {2'b00, w[j]} + {2'b00, w[j+1]} + {2'b00, w[j+2]};
            w[j+3] = s[DW-1:0];
            f[j+3] = f[j] | f[j+1] | f[j+2] | (|s[DW+1:DW]);
            a = {1'b0, acc_n} + {1'b0, w[j]};
            acc_n = sh[j] ? a[DW-1:0] : acc_n;
            ovf_n = ovf_n | (sh[j] & (a[DW] | f[j]));
            err_n = err_n | (&b[j +: 3]);
        end
        wn0 = w[BPC];
        wn1 = w[BPC+1];
        wn2 = w[BPC+2];
        fn0 = f[BPC];
        fn1 = f[BPC+1];
        fn2 = f[BPC+2];
        prev_n = b[BPC+1:BPC];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            step  <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                sh    <= SW'(codein);
                acc   <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
                w0    <= DW'(1);
                w1    <= DW'(2);
                w2    <= DW'(4);
                f0    <= 1'b0;
                f1    <= 1'b0;
                f2    <= 1'b0;
                prev  <= 2'b00;
                step  <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            sh    <= sh >> BPC;
            acc   <= acc_n;
            err   <= err_n;
            ovf   <= ovf_n;
            w0    <= wn0;
            w1    <= wn1;
            w2    <= wn2;
            f0    <= fn0;
            f1    <= fn1;
            f2    <= fn2;
            prev  <= prev_n;
            step  <= step + SCW'(1);
            state <= step == SCW'(NSTEP - 1) ? DONE : RUN;
        end else if (out_ready) begin
            state <= IDLE;
        end
    end
endmodule
